// File: rtl/nco_phase_gen.sv
// Numerically controlled oscillator phase generator with a sample-rate divider, fcw handshake and hard sync.
// Optional phase dither is enabled by defining NCO_PHASE_DITHER_EN.
module nco_phase_gen #(
    parameter int ACC_WIDTH   = 24,
    parameter int PHASE_WIDTH = 15,
    parameter int SAMPLE_DIV  = 2500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [ACC_WIDTH-1:0]   fcw,
    input  logic                   fcw_valid,
    output logic                   fcw_ready,
    input  logic                   hard_sync,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic                   phase_valid,
    output logic                   wrap
);

    localparam int CW = $clog2(SAMPLE_DIV);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        count;
    logic [ACC_WIDTH-1:0] acc, active_fcw, shadow, inc, acc_next;
    logic [ACC_WIDTH:0]   sum;
    logic                 pending, sync_pending, tick, carry, accept;
    logic [PHASE_WIDTH-1:0] phase_next;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign tick      = (state == RUN) && (count == CW'(SAMPLE_DIV - 1));
    assign inc       = pending ? shadow : active_fcw;
    assign sum       = {1'b0, acc} + {1'b0, inc};
    // A pending sync restarts accumulation from zero, so no carry can be reported.
    assign acc_next  = sync_pending ? inc : sum[ACC_WIDTH-1:0];
    assign carry     = !sync_pending && sum[ACC_WIDTH];
    assign accept    = fcw_valid && !pending;
    assign fcw_ready = !pending;

`ifdef NCO_PHASE_DITHER_EN
    localparam int DW = ACC_WIDTH - PHASE_WIDTH;

    logic [15:0]          lfsr;
    logic [ACC_WIDTH-1:0] dither_ext, dith_sum;

    // Galois LFSR for x^16+x^14+x^13+x^11+1, stepped once per tick.
    always_ff @(posedge clk) begin
        if (rst)       lfsr <= 16'hACE1;
        else if (tick) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always_comb begin
        dither_ext = '0;
        for (int i = 0; i < DW && i < 16; i++) dither_ext[i] = lfsr[i];
    end

    assign dith_sum   = acc_next + dither_ext;
    assign phase_next = dith_sum[ACC_WIDTH-1 -: PHASE_WIDTH];
`else
    assign phase_next = acc_next[ACC_WIDTH-1 -: PHASE_WIDTH];
`endif

    // Divider, accumulator, fcw shadow handshake and sync flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            acc          <= '0;
            phase        <= '0;
            active_fcw   <= '0;
            shadow       <= '0;
            pending      <= 1'b0;
            sync_pending <= 1'b0;
            phase_valid  <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            if (state == RUN && enable) count <= tick ? '0 : count + CW'(1);
            else                        count <= '0;
            phase_valid <= tick;
            wrap        <= tick && carry;
            if (tick) begin
                acc   <= acc_next;
                phase <= phase_next;
            end
            if (tick && pending) active_fcw <= shadow;
            if (accept) begin
                shadow  <= fcw;
                pending <= 1'b1;
            end else if (tick) begin
                pending <= 1'b0;
            end
            if (hard_sync) sync_pending <= 1'b1;
            else if (tick) sync_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Self-checking bench for nco_phase_gen (dither off, SAMPLE_DIV=4) against a cycle-level arithmetic model.
module tb_nco_phase_gen;

    localparam int ACC = 24;
    localparam int PW  = 15;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          rst, enable, fcw_valid, hard_sync;
    logic [ACC-1:0] fcw;
    logic          fcw_ready, phase_valid, wrap;
    logic [PW-1:0] phase;

    int nChecks = 0;
    int nFails  = 0;

    bit     mRun, mPend, mSync, mPv, mWrap;
    int     mCnt;
    longint mAcc, mActive, mShadow, mPhase;

    nco_phase_gen #(.ACC_WIDTH(ACC), .PHASE_WIDTH(PW), .SAMPLE_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fcw(fcw), .fcw_valid(fcw_valid),
        .fcw_ready(fcw_ready), .hard_sync(hard_sync), .phase(phase),
        .phase_valid(phase_valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        nChecks++;
        if (got != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour for one clock edge, from the block's rules in integer arithmetic.
    task automatic modelEdge(input bit r, input bit en, input longint f, input bit fv, input bit hs);
        bit     tick, acc;
        longint inc, total;
        if (r) begin
            mRun = 0; mCnt = 0; mAcc = 0; mPhase = 0; mActive = 0; mShadow = 0;
            mPend = 0; mSync = 0; mPv = 0; mWrap = 0;
            return;
        end
        tick = mRun && (mCnt == DIV - 1);
        inc  = mPend ? mShadow : mActive;
        acc  = fv && !mPend;
        mPv = tick;
        mWrap = 0;
        if (tick) begin
            total  = mSync ? inc : mAcc + inc;
            mWrap  = !mSync && (total >= (64'd1 << ACC));
            mAcc   = total % (64'd1 << ACC);
            mPhase = mAcc / (64'd1 << (ACC - PW));
            if (mPend) begin mActive = mShadow; mPend = 0; end
            mSync = 0;
        end
        if (acc) begin mShadow = f; mPend = 1; end
        if (hs) mSync = 1;
        mCnt = (mRun && en) ? (tick ? 0 : mCnt + 1) : 0;
        mRun = en;
    endtask

    task automatic applyStimulus(input bit r, input bit en, input logic [ACC-1:0] f,
                                 input bit fv, input bit hs);
        rst = r; enable = en; fcw = f; fcw_valid = fv; hard_sync = hs;
        @(posedge clk);
        modelEdge(r, en, longint'(f), fv, hs);
        #1;
        checkOutput("phase", longint'(phase), mPhase);
        checkOutput("phase_valid", longint'(phase_valid), longint'(mPv));
        checkOutput("wrap", longint'(wrap), longint'(mWrap));
        checkOutput("fcw_ready", longint'(fcw_ready), longint'(!mPend));
    endtask

    // Runs enabled until the next phase_valid, then checks it against fixed values.
    task automatic expectPhase(input string tag, input longint ph, input longint wr);
        int n = 0;
        do begin
            applyStimulus(0, 1, '0, 0, 0);
            n++;
        end while (!phase_valid && n < 20);
        checkOutput({tag, "_timeout"}, longint'(phase_valid), 1);
        checkOutput({tag, "_phase"}, longint'(phase), ph);
        checkOutput({tag, "_wrap"}, longint'(wrap), wr);
    endtask

    initial begin
        int n;
        applyStimulus(1, 0, '0, 0, 0);
        checkOutput("rst_phase", longint'(phase), 0);
        checkOutput("rst_ready", longint'(fcw_ready), 1);

        applyStimulus(0, 1, 24'h001000, 1, 0);
        expectPhase("seq0", 'h0008, 0);
        expectPhase("seq1", 'h0010, 0);
        expectPhase("seq2", 'h0018, 0);

        applyStimulus(0, 1, 24'h000800, 0, 1);
        expectPhase("sync", 'h0008, 0);

        applyStimulus(0, 1, 24'h002000, 1, 0);
        applyStimulus(0, 1, 24'h00F000, 1, 0);
        checkOutput("busy_ready", longint'(fcw_ready), 0);
        expectPhase("newfcw", 'h0018, 0);
        checkOutput("ready_after", longint'(fcw_ready), 1);

        for (int i = 0; i < 10; i++) applyStimulus(0, 0, '0, 0, 0);
        n = 0;
        do begin
            applyStimulus(0, 1, '0, 0, 0);
            n++;
        end while (!phase_valid && n < 20);
        checkOutput("resume_latency", n, DIV + 1);

        applyStimulus(1, 0, '0, 0, 0);
        applyStimulus(0, 1, 24'h400000, 1, 0);
        expectPhase("wr0", 'h2000, 0);
        expectPhase("wr1", 'h4000, 0);
        expectPhase("wr2", 'h6000, 0);
        expectPhase("wr3", 'h0000, 1);

        applyStimulus(0, 1, 24'h123456, 1, 0);
        applyStimulus(1, 1, '0, 0, 0);
        checkOutput("rstpend_ready", longint'(fcw_ready), 1);
        checkOutput("rstpend_phase", longint'(phase), 0);
        expectPhase("rstpend_first", 'h0000, 0);

        for (int i = 0; i < 600; i++)
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                          ACC'($urandom), ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
